// File: rtl/dcm_pkg.sv
// Shared types and helpers for the down-count monitor.
// The report record is sized by DcmCntW; the top's CNT_W is expected to match it.
package dcm_pkg;

    localparam int unsigned DcmCntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StTrack,
        StFault
    } dcm_state_e;

    typedef struct packed {
        logic [DcmCntW-1:0] err_count;
        logic [DcmCntW-1:0] wrap_count;
    } rpt_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/dcm_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Exposes the next-state value so callers can snapshot post-increment counts.
module dcm_sat_counter
    import dcm_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] count_d_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = Width'(sat_inc(32'(count_q), Width));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/down_count_monitor.sv
// Checks that a W-bit down counter steps by exactly -1 mod 2^W, counts wraps and errors,
// and emits a report every RPT_WRAPS wraps. DCM_STALL_CHECK_EN adds the stall detector.
module down_count_monitor
    import dcm_pkg::*;
#(
    parameter int unsigned W           = 3,
    parameter int unsigned CNT_W       = DcmCntW,
    parameter int unsigned RPT_WRAPS   = 4,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       q_in,
    input  logic               sample_en,
    input  logic               clear,
    output logic               wrap_pulse,
    output logic               err,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   wrap_count,
    output logic               locked,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [2*CNT_W-1:0] rpt_data,
    output logic               rpt_overrun
`ifdef DCM_STALL_CHECK_EN
    ,
    output logic               stall
`endif
);

    dcm_state_e       state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             err_q, err_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             fault_run_q, fault_run_d;
    logic [CNT_W-1:0] tally_q, tally_d;
    logic             rpt_valid_q, rpt_valid_d;
    rpt_t             rpt_q, rpt_d;
    logic             overrun_q, overrun_d;

    logic [W-1:0]     expected;
    logic             match;
    logic             step_bad;
    logic             tracking;
    logic             wrap_event;
    logic             err_inc;
    logic             rpt_due;
    logic             accept;
    logic [CNT_W-1:0] err_count_d, wrap_count_d;

    assign expected   = prev_q - W'(1);
    assign match      = (q_in == expected);
    assign tracking   = (state_q == StTrack) || (state_q == StFault);
    assign wrap_event = sample_en && !clear && tracking && match && (prev_q == '0);

`ifdef DCM_STALL_CHECK_EN
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

    logic              same;
    logic              stall_hit;
    logic              stall_q, stall_d;
    logic [StallW-1:0] stall_run_q, stall_run_d;

    // An unchanged sample feeds the stall run instead of counting as a bad step.
    assign same     = (q_in == prev_q);
    assign step_bad = !match && !same;

    dcm_sat_counter #(
        .Width (StallW)
    ) u_stall_run (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clear || (sample_en && !(tracking && same))),
        .inc_i     (sample_en && tracking && same),
        .count_o   (stall_run_q),
        .count_d_o (stall_run_d)
    );

    assign stall_hit = !clear && (stall_run_d == StallW'(STALL_LIMIT))
                       && (stall_run_q != StallW'(STALL_LIMIT));
    assign stall_d   = clear ? 1'b0 : (stall_q || stall_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign step_bad = !match;
`endif

    always_comb begin
        state_d     = state_q;
        fault_run_d = fault_run_q;
        err_d       = err_q;
        err_inc     = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (match) state_d = StTrack;
                end
                StTrack: begin
                    if (step_bad) begin
                        state_d     = StFault;
                        err_d       = 1'b1;
                        err_inc     = 1'b1;
                        fault_run_d = 1'b0;
                    end
                end
                StFault: begin
                    // Two consecutive good steps are needed before trusting the counter again.
                    if (match) begin
                        if (fault_run_q) begin
                            state_d     = StTrack;
                            fault_run_d = 1'b0;
                        end else begin
                            fault_run_d = 1'b1;
                        end
                    end else if (step_bad) begin
                        err_inc     = 1'b1;
                        fault_run_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef DCM_STALL_CHECK_EN
        if (stall_hit) begin
            state_d     = StFault;
            fault_run_d = 1'b0;
        end
`endif
        if (clear) begin
            state_d     = StIdle;
            fault_run_d = 1'b0;
            err_d       = 1'b0;
            err_inc     = 1'b0;
        end
    end

    assign prev_d       = clear ? '0 : (sample_en ? q_in : prev_q);
    assign wrap_pulse_d = wrap_event;

    dcm_sat_counter #(
        .Width (CNT_W)
    ) u_err_count (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clear),
        .inc_i     (err_inc),
        .count_o   (err_count),
        .count_d_o (err_count_d)
    );

    dcm_sat_counter #(
        .Width (CNT_W)
    ) u_wrap_count (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clear),
        .inc_i     (wrap_event),
        .count_o   (wrap_count),
        .count_d_o (wrap_count_d)
    );

    assign accept = rpt_valid_q && rpt_ready;

    always_comb begin
        tally_d     = tally_q;
        rpt_due     = 1'b0;
        rpt_valid_d = rpt_valid_q;
        rpt_d       = rpt_q;
        overrun_d   = overrun_q;
        if (wrap_event) begin
            if (tally_q == CNT_W'(RPT_WRAPS - 1)) begin
                tally_d = '0;
                rpt_due = 1'b1;
            end else begin
                tally_d = tally_q + CNT_W'(1);
            end
        end
        if (accept) begin
            rpt_valid_d = 1'b0;
        end
        // A slot freed by acceptance this cycle can take the new record directly.
        if (rpt_due) begin
            if (!rpt_valid_q || accept) begin
                rpt_d.err_count  = err_count_d;
                rpt_d.wrap_count = wrap_count_d;
                rpt_valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clear) begin
            tally_d     = '0;
            rpt_valid_d = 1'b0;
            rpt_d       = '0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            err_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
            fault_run_q  <= 1'b0;
            tally_q      <= '0;
            rpt_valid_q  <= 1'b0;
            rpt_q        <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            err_q        <= err_d;
            wrap_pulse_q <= wrap_pulse_d;
            fault_run_q  <= fault_run_d;
            tally_q      <= tally_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_q        <= rpt_d;
            overrun_q    <= overrun_d;
        end
    end

    assign wrap_pulse  = wrap_pulse_q;
    assign err         = err_q;
    assign locked      = (state_q == StTrack);
    assign rpt_valid   = rpt_valid_q;
    assign rpt_data    = rpt_q;
    assign rpt_overrun = overrun_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor (W=3, CNT_W=8, RPT_WRAPS=4).
// The stall checks are built only when DCM_STALL_CHECK_EN is defined.
module tb_down_count_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  q_in = '0;
    logic        sample_en = 1'b0;
    logic        clear = 1'b0;
    logic        rpt_ready = 1'b0;
    logic        wrap_pulse;
    logic        err;
    logic [7:0]  err_count;
    logic [7:0]  wrap_count;
    logic        locked;
    logic        rpt_valid;
    logic [15:0] rpt_data;
    logic        rpt_overrun;
`ifdef DCM_STALL_CHECK_EN
    logic        stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    down_count_monitor #(
        .W           (3),
        .CNT_W       (8),
        .RPT_WRAPS   (4),
        .STALL_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .q_in        (q_in),
        .sample_en   (sample_en),
        .clear       (clear),
        .wrap_pulse  (wrap_pulse),
        .err         (err),
        .err_count   (err_count),
        .wrap_count  (wrap_count),
        .locked      (locked),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_data    (rpt_data),
        .rpt_overrun (rpt_overrun)
`ifdef DCM_STALL_CHECK_EN
        ,
        .stall       (stall)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] q, input logic en);
        @(negedge clk);
        q_in      = q;
        sample_en = en;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic feed_down(input logic [2:0] start, input int n);
        logic [2:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            step(v, 1'b1);
            if (wrap_pulse) pulses++;
            v = v - 3'd1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear     = 1'b1;
        sample_en = 1'b1;
        q_in      = 3'd5;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        sample_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'd0);
        check_eq({tag, ".err"}, 32'(err), 32'd0);
        check_eq({tag, ".err_count"}, 32'(err_count), 32'd0);
        check_eq({tag, ".wrap_count"}, 32'(wrap_count), 32'd0);
        check_eq({tag, ".locked"}, 32'(locked), 32'd0);
        check_eq({tag, ".rpt_valid"}, 32'(rpt_valid), 32'd0);
        check_eq({tag, ".rpt_data"}, 32'(rpt_data), 32'd0);
        check_eq({tag, ".rpt_overrun"}, 32'(rpt_overrun), 32'd0);
`ifdef DCM_STALL_CHECK_EN
        check_eq({tag, ".stall"}, 32'(stall), 32'd0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean sequence 7..0,7..0: lock on the 2nd sample, one wrap.
        pulses = 0;
        step(3'd7, 1'b1);
        check_eq("t1.locked_s1", 32'(locked), 32'd0);
        step(3'd6, 1'b1);
        check_eq("t1.locked_s2", 32'(locked), 32'd1);
        feed_down(3'd5, 14);
        check_eq("t1.pulses", 32'(pulses), 32'd1);
        check_eq("t1.wrap_count", 32'(wrap_count), 32'd1);
        check_eq("t1.err", 32'(err), 32'd0);
        check_eq("t1.locked", 32'(locked), 32'd1);

        // Skip 3: fault, then two matches re-lock; 0->7 still wraps.
        feed_down(3'd7, 4);
        check_eq("t2.wrap_count", 32'(wrap_count), 32'd2);
        step(3'd2, 1'b1);
        check_eq("t2.err", 32'(err), 32'd1);
        check_eq("t2.err_count", 32'(err_count), 32'd1);
        check_eq("t2.locked_fault", 32'(locked), 32'd0);
        step(3'd1, 1'b1);
        check_eq("t2.locked_m1", 32'(locked), 32'd0);
        step(3'd0, 1'b1);
        check_eq("t2.locked_m2", 32'(locked), 32'd1);
        step(3'd7, 1'b1);
        check_eq("t2.locked_7", 32'(locked), 32'd1);
        check_eq("t2.wrap_count2", 32'(wrap_count), 32'd3);
        step(3'd3, 1'b0);
        check_eq("t2.nosample_err_count", 32'(err_count), 32'd1);
        check_eq("t2.nosample_locked", 32'(locked), 32'd1);

        do_clear();
        check_zero("clear1");

        // Report after 4 wraps, then overrun while unaccepted.
        feed_down(3'd7, 32);
        check_eq("t3.valid_before", 32'(rpt_valid), 32'd0);
        step(3'd7, 1'b1);
        check_eq("t3.valid", 32'(rpt_valid), 32'd1);
        check_eq("t3.data", 32'(rpt_data), 32'h0004);
        feed_down(3'd6, 32);
        check_eq("t3.wrap_count", 32'(wrap_count), 32'd8);
        check_eq("t3.overrun", 32'(rpt_overrun), 32'd1);
        check_eq("t3.data_held", 32'(rpt_data), 32'h0004);
        check_eq("t3.valid_held", 32'(rpt_valid), 32'd1);
        @(negedge clk);
        rpt_ready = 1'b1;
        @(posedge clk);
        #1;
        rpt_ready = 1'b0;
        check_eq("t3.valid_after_accept", 32'(rpt_valid), 32'd0);

        // Accept on the same cycle the next report becomes due.
        do_clear();
        feed_down(3'd7, 33);
        check_eq("t4.valid", 32'(rpt_valid), 32'd1);
        check_eq("t4.data", 32'(rpt_data), 32'h0004);
        feed_down(3'd6, 31);
        @(negedge clk);
        q_in      = 3'd7;
        sample_en = 1'b1;
        rpt_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        rpt_ready = 1'b0;
        check_eq("t4.valid_kept", 32'(rpt_valid), 32'd1);
        check_eq("t4.data_new", 32'(rpt_data), 32'h0008);
        check_eq("t4.overrun", 32'(rpt_overrun), 32'd0);
        step(3'd0, 1'b0);
        check_eq("t4.valid_stable", 32'(rpt_valid), 32'd1);
        check_eq("t4.data_stable", 32'(rpt_data), 32'h0008);

        // Asynchronous reset drops a pending report between clock edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t4.async_valid", 32'(rpt_valid), 32'd0);
        check_eq("t4.async_data", 32'(rpt_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 300 wraps saturate wrap_count at 255.
        feed_down(3'd7, 2401);
        check_eq("t5.wrap_sat", 32'(wrap_count), 32'd255);
        check_eq("t5.err", 32'(err), 32'd0);
        do_clear();
        check_zero("clear2");
        step(3'd7, 1'b1);
        check_eq("t5.idle_after_clear", 32'(locked), 32'd0);

`ifdef DCM_STALL_CHECK_EN
        // Four unchanged samples in TRACK raise stall without err.
        do_clear();
        feed_down(3'd7, 5);
        check_eq("t6.locked", 32'(locked), 32'd1);
        for (int i = 0; i < 3; i++) step(3'd3, 1'b1);
        check_eq("t6.stall_early", 32'(stall), 32'd0);
        check_eq("t6.locked_early", 32'(locked), 32'd1);
        step(3'd3, 1'b1);
        check_eq("t6.stall", 32'(stall), 32'd1);
        check_eq("t6.locked_stall", 32'(locked), 32'd0);
        check_eq("t6.err", 32'(err), 32'd0);
        step(3'd3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6.async_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Downstream checker for the 3-bit mod-8 down counter. Samples the counter output each enabled cycle and verifies every step is exactly a decrement by 1 modulo 2^W. Counts wrap-arounds (0 -> max) and step errors. Every RPT_WRAPS wraps it emits a report record over a valid/ready handshake.

Parameters:
W, 3, counter width monitored; modulus 2^W
CNT_W, 8, width of wrap and error counters (saturating)
RPT_WRAPS, 4, wraps per report record; legal range 1..2^CNT_W-1
STALL_LIMIT, 4, consecutive unchanged samples that flag a stall (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
q_in  in  W  counter value under test
sample_en  in  1  sample q_in this cycle
clear  in  1  synchronous clear of counters, flags and FSM (returns to IDLE)
wrap_pulse  out  1  one-cycle pulse on a detected wrap (prev=0, cur=2^W-1)
err  out  1  sticky step-error flag
err_count  out  CNT_W  saturating count of bad steps
wrap_count  out  CNT_W  saturating count of wraps
locked  out  1  high while FSM in TRACK
rpt_valid  out  1  report available
rpt_ready  in  1  consumer accepts report
rpt_data  out  2*CNT_W  {err_count, wrap_count} snapshot at report time
rpt_overrun  out  1  sticky: a report came due while rpt_valid was still high

Behaviour:
- Reset or clear: all outputs 0; FSM=IDLE; prev register=0. clear has priority over sample_en in the same cycle.
- prev register: loaded with q_in on every sample_en cycle. expected = prev - 1, truncated to W bits, so 0 -> 2^W-1.
- FSM states:
  - IDLE: first sample_en captures prev -> SYNC.
  - SYNC: next sample: match -> TRACK; mismatch -> stay SYNC, no error recorded.
  - TRACK: match -> stay; mismatch -> FAULT, err<=1, err_count+1.
  - FAULT: requires two consecutive matching samples -> TRACK. Each further mismatch increments err_count and resets the match run.
- No sample_en: no state change, no counting.
- Wrap detection: active in TRACK and FAULT only. Condition is a matching sample with prev=0 and q_in=2^W-1.
  - wrap_pulse is registered and asserts the cycle after the sample.
  - wrap_count increments on the same event.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Report: internal wrap tally counts 1..RPT_WRAPS. When it reaches RPT_WRAPS, the tally resets to 0.
  - If rpt_valid=0: rpt_data <= {err_count_next, wrap_count_next} and rpt_valid<=1 on the next cycle.
  - If rpt_valid=1: the report is dropped, rpt_data is unchanged, and rpt_overrun<=1.
- Handshake: rpt_valid and rpt_data are held stable until rpt_valid && rpt_ready. rpt_valid then drops the next cycle.
  - Acceptance and a new report due in the same cycle: the new report loads and rpt_valid stays 1; no overrun.
- Reset mid-report: rpt_valid drops immediately (async); no record is retained.
- Latency: sample to err/wrap_pulse/counters is 1 cycle; sample to rpt_valid is 1 cycle.

Optional Feature:
DCM_STALL_CHECK_EN defined:
- Adds output stall (1 bit, sticky, reset 0).
- A stall run counts consecutive samples where q_in equals prev, in TRACK or FAULT.
- When the run reaches STALL_LIMIT: stall<=1 and the FSM goes to FAULT. err is not set.
- Any changed sample clears the run.
Undefined: no stall port; an unchanged sample is an ordinary mismatch.

Decomposition:
- Package dcm_pkg:
  - state enum {IDLE, SYNC, TRACK, FAULT}
  - rpt_t struct {err_count, wrap_count}
  - function sat_inc(value, width)
- Sub-module dcm_sat_counter (CNT_W, increment enable, sync clear, async rst). Instantiated for err_count, wrap_count and the stall run.

Test Plan:
- Feed 7,6,...,0,7,...,0 (16 samples, sample_en=1) -> locked from 3rd sample; wrap_pulse once; wrap_count=1; err=0.
- In TRACK feed 5,4,2,1,0 -> err=1, err_count=1, locked=0 after 2. Re-locks after 1,0 (two matches); stays locked at 7.
- RPT_WRAPS=4, 4 full down cycles, rpt_ready=0 -> rpt_valid=1, rpt_data={0,4}. Four more wraps -> rpt_overrun=1, rpt_data still {0,4}.
- rpt_ready=1 on the same cycle the 8th wrap completes -> rpt_data={0,8}, rpt_valid stays 1, rpt_overrun=0.
- 300 clean wraps -> wrap_count=255 (saturated). clear=1 with sample_en=1 -> all outputs 0, FSM IDLE.
- With DCM_STALL_CHECK_EN, STALL_LIMIT=4: hold q_in=3 for 4 samples in TRACK -> stall=1, locked=0, err=0. Assert rst mid-hold -> stall=0 asynchronously.
